// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle multiply/divide responder for the control unit's mult_div
//   command. A one-cycle start in IDLE latches operands; the unit then runs
//   one Booth step (mult) or one restoring-division step (div) per cycle and
//   commits HI/LO in a single FINISH cycle, pulsing done.
//
//   Optional feature macro: MULT_DIV_MULTU_EN
//     defined   : op==11 is an unsigned multiply (WIDTH+1 Booth iterations)
//     undefined : op==11 is ignored like op==00
//
// Ports
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high reset (aborts any operation, no done)
//   start  : one-cycle command strobe, sampled only in IDLE
//   op     : 00 none, 01 mult (signed), 10 div (signed), 11 multu/ignored
//   a, b   : operands (register A / register B), latched at accept
//   hi, lo : HI/LO result registers (upper product/remainder, lower/quotient)
//   busy   : high in MULT, DIV and FINISH
//   done   : one-cycle pulse on commit, or on a divide-by-zero abort
//   div0   : one-cycle pulse coincident with done when a divide had b==0

module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             div0
);

   // Multiplier register needs one extra bit when unsigned operands must be
   // zero-extended into the signed Booth datapath.
`ifdef MULT_DIV_MULTU_EN
   localparam int QW = WIDTH + 1;
`else
   localparam int QW = WIDTH;
`endif
   // One guard bit over the multiplier width keeps P+/-M from overflowing,
   // including the most-negative multiplicand case.
   localparam int PW = QW + 1;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_FINISH} state_t;
   state_t state, state_nxt;

   // Shared datapath: mult uses {acc_p, acc_q, qm1} as the Booth accumulator
   // with mcand as multiplicand; div uses acc_p as partial remainder, acc_q as
   // dividend/quotient shift register and mcand as |divisor|.
   logic [PW-1:0]    acc_p, mcand;
   logic [QW-1:0]    acc_q;
   logic             qm1;
   logic [CW-1:0]    cnt;
   logic             is_div, neg_q, neg_r;

   logic             cmd_mult, cmd_multu, cmd_div, b_zero;
   logic             last_mult, last_div;
   logic [PW-1:0]    a_ext;
   logic [QW-1:0]    b_ext;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [PW-1:0]    booth_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_borrow;
   logic [WIDTH-1:0] prod_hi, prod_lo, quo, rem;

   assign cmd_mult = start && (op == 2'b01);
   assign cmd_div  = start && (op == 2'b10);
   assign b_zero   = (b == '0);
   assign busy     = (state != S_IDLE);
   assign last_div = (cnt == CW'(WIDTH - 1));

`ifdef MULT_DIV_MULTU_EN
   logic is_multu;
   assign cmd_multu = start && (op == 2'b11);
   assign last_mult = is_multu ? (cnt == CW'(WIDTH)) : (cnt == CW'(WIDTH - 1));
`else
   assign cmd_multu = 1'b0;
   assign last_mult = (cnt == CW'(WIDTH - 1));
`endif

   // Operand extension into the Booth datapath
   always_comb begin
      a_ext = PW'($signed(a));
      b_ext = QW'($signed(b));
`ifdef MULT_DIV_MULTU_EN
      if (op == 2'b11) begin
         a_ext = PW'(a);
         b_ext = QW'(b);
      end
`endif
   end

   assign a_mag = a[WIDTH-1] ? -a : a;
   assign b_mag = b[WIDTH-1] ? -b : b;

   // Booth recoding of the current multiplier bit pair
   always_comb begin
      case ({acc_q[0], qm1})
         2'b01:   booth_sum = acc_p + mcand;
         2'b10:   booth_sum = acc_p - mcand;
         default: booth_sum = acc_p;
      endcase
   end

   // Restoring division step: shift next dividend bit in, trial-subtract
   assign div_shift  = {acc_p[WIDTH-1:0], acc_q[WIDTH-1]};
   assign div_diff   = {1'b0, div_shift} - {2'b00, mcand[WIDTH-1:0]};
   assign div_borrow = div_diff[WIDTH+1];

   // Product alignment: signed mult shifts WIDTH times, so with the wider
   // multiplier register the low word sits one bit up.
`ifdef MULT_DIV_MULTU_EN
   assign prod_lo = is_multu ? acc_q[WIDTH-1:0] : acc_q[WIDTH:1];
   assign prod_hi = is_multu ? {acc_p[WIDTH-2:0], acc_q[WIDTH]} : acc_p[WIDTH-1:0];
`else
   assign prod_lo = acc_q;
   assign prod_hi = acc_p[WIDTH-1:0];
`endif

   assign quo = acc_q[WIDTH-1:0];
   assign rem = acc_p[WIDTH-1:0];

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cmd_mult || cmd_multu)     state_nxt = S_MULT;
            else if (cmd_div && !b_zero)   state_nxt = S_DIV;
         end
         S_MULT:   if (last_mult) state_nxt = S_FINISH;
         S_DIV:    if (last_div)  state_nxt = S_FINISH;
         S_FINISH: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= S_IDLE;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
         div0   <= 1'b0;
         cnt    <= '0;
         acc_p  <= '0;
         acc_q  <= '0;
         mcand  <= '0;
         qm1    <= 1'b0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
`ifdef MULT_DIV_MULTU_EN
         is_multu <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         div0  <= 1'b0;
         case (state)
            S_IDLE: begin
               cnt <= '0;
               if (cmd_mult || cmd_multu) begin
                  acc_p  <= '0;
                  acc_q  <= b_ext;
                  mcand  <= a_ext;
                  qm1    <= 1'b0;
                  is_div <= 1'b0;
`ifdef MULT_DIV_MULTU_EN
                  is_multu <= cmd_multu;
`endif
               end else if (cmd_div) begin
                  if (b_zero) begin
                     // Abort straight from IDLE; hi/lo keep their values
                     done <= 1'b1;
                     div0 <= 1'b1;
                  end else begin
                     acc_p  <= '0;
                     acc_q  <= QW'(a_mag);
                     mcand  <= PW'(b_mag);
                     is_div <= 1'b1;
                     neg_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                     neg_r  <= a[WIDTH-1];
                  end
               end
            end
            S_MULT: begin
               // Arithmetic right shift of {P, Q, q-1}
               {acc_p, acc_q, qm1} <= {booth_sum[PW-1], booth_sum, acc_q};
               cnt <= cnt + 1'b1;
            end
            S_DIV: begin
               acc_p <= div_borrow ? PW'(div_shift) : PW'(div_diff[WIDTH:0]);
               acc_q <= {acc_q[QW-2:0], ~div_borrow};
               cnt   <= cnt + 1'b1;
            end
            S_FINISH: begin
               if (is_div) begin
                  lo <= neg_q ? -quo : quo;
                  hi <= neg_r ? -rem : rem;
               end else begin
                  lo <= prod_lo;
                  hi <= prod_hi;
               end
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected results
// (hi, lo, div0, cycle of done) into a queue; a monitor pops on every done.
module tb_mult_div_unit;
   localparam int W = 32;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [1:0]   op    = 2'b00;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic [W-1:0] hi, lo;
   logic         busy, done, div0;

   mult_div_unit #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         div0;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [W-1:0] cur_hi = '0, cur_lo = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done must match the oldest expectation, on time
   always @(negedge clock) begin
      if (!reset) begin
         if (div0) chk("div0_with_done", W'(done), W'(1));
         if (done) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("done_cycle", W'(cyc), W'(e.cyc));
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
               chk("div0", W'(div0), W'(e.div0));
            end
         end
      end
   end

   // Issue one command; lat = edges from accept edge to done-visible edge
   task automatic issue(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input bit expect_done, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed, input int lat);
      @(negedge clock);
      start = 1'b1; op = o; a = av; b = bv;
      if (expect_done) begin
         exp_t e;
         e.hi = eh; e.lo = el; e.div0 = ed; e.cyc = cyc + 1 + lat;
         exp_q.push_back(e);
         cur_hi = eh; cur_lo = el;
      end
      @(negedge clock);
      start = 1'b0; op = 2'b00; a = ~av; b = ~bv;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clock); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // After a done: pulse must be single and busy must be low
   task automatic post_done();
      chk("busy_at_done", W'(busy), W'(0));
      @(negedge clock); #1;
      chk("done_single", W'(done), W'(0));
      chk("busy_after", W'(busy), W'(0));
   endtask

   task automatic run(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] eh, input logic [W-1:0] el);
      issue(o, av, bv, 1'b1, eh, el, 1'b0, W + 1);
      drain();
      post_done();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_hi", hi, '0);
      chk("rst_lo", lo, '0);
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_div0", W'(div0), W'(0));
      reset = 1'b0;

      // Signed multiplies
      run(2'b01, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run(2'b01, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'd30);
      run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);
      run(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);

      // Signed divides (remainder sign follows dividend)
      run(2'b10, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
      run(2'b10, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h7FFF_FFFF);
      run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

      // Prime hi=0x11, lo=0x22, then divide by zero: immediate abort
      run(2'b10, 32'h451, 32'h20, 32'h11, 32'h22);
      issue(2'b10, 32'd100, 32'd0, 1'b1, 32'h11, 32'h22, 1'b1, 0);
      #1;
      chk("div0_busy0", W'(busy), W'(0));
      drain();
      post_done();
      chk("div0_hold_hi", hi, 32'h11);
      chk("div0_hold_lo", lo, 32'h22);

      // start during busy is ignored; operand changes have no effect
      issue(2'b01, 32'h1234, 32'h10, 1'b1, 32'h0, 32'h12340, 1'b0, W + 1);
      repeat (3) @(negedge clock);
      start = 1'b1; op = 2'b10; a = 32'd5; b = 32'd0;
      #1;
      chk("busy_mid", W'(busy), W'(1));
      chk("hold_hi_mid", hi, 32'h11);
      chk("hold_lo_mid", lo, 32'h22);
      @(negedge clock);
      start = 1'b0; op = 2'b00; a = 32'hDEAD_BEEF; b = 32'h0;
      drain();
      post_done();
      repeat (4) @(negedge clock);

      // Reset at cycle 10 of a divide aborts with no done
      issue(2'b10, 32'd1000, 32'd7, 1'b0, '0, '0, 1'b0, 0);
      repeat (8) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("abort_hi", hi, '0);
      chk("abort_lo", lo, '0);
      chk("abort_busy", W'(busy), W'(0));
      chk("abort_done", W'(done), W'(0));
      repeat (40) @(negedge clock);

      // op==00 is ignored
      issue(2'b00, 32'd3, 32'd4, 1'b0, '0, '0, 1'b0, 0);
      #1;
      chk("op00_busy", W'(busy), W'(0));

`ifdef MULT_DIV_MULTU_EN
      issue(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h1, 32'hFFFF_FFFE, 1'b0, W + 2);
      drain();
      post_done();
`else
      issue(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b0, '0, '0, 1'b0, 0);
      #1;
      chk("op11_busy", W'(busy), W'(0));
      repeat (40) @(negedge clock);
      chk("op11_busy_late", W'(busy), W'(0));
`endif

      repeat (3) @(negedge clock);
      chk("queue_empty", W'(exp_q.size()), W'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
